// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and counter-width helper for serial_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: single-bit full adder from two half-adder stages and an OR
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s1, c1, c2;
  assign s1   = a ^ b;
  assign c1   = a & b;
  assign s    = s1 ^ cin;
  assign c2   = s1 & cin;
  assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with valid/ready handshakes; SERIAL_ADDER_SUB_EN adds a subtract port
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);
  localparam int CNT_W = cnt_w(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CNT_W-1:0] cnt;
  logic c_reg, b_in, fa_s, fa_c, last, accept;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub_r;
  always_ff @(posedge clk)
    if (rst) sub_r <= 1'b0;
    else if (accept) sub_r <= sub;
  assign b_in = b_sh[0] ^ sub_r;
  wire sub_start = sub;
`else
  assign b_in = b_sh[0];
  wire sub_start = 1'b0;
`endif
  full_adder_cell u_fa (.a(a_sh[0]), .b(b_in), .cin(c_reg), .s(fa_s), .cout(fa_c));
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_ready && in_valid;
  assign last      = cnt == CNT_W'(WIDTH - 1);
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (in_valid ? RUN : IDLE) :
               (state == RUN)  ? (last ? DONE : RUN) :
               (state == DONE) ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      c_reg <= 1'b0;
      Sum   <= '0;
      Carry <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh  <= A;
        b_sh  <= B;
        cnt   <= '0;
        c_reg <= sub_start;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        cnt   <= cnt + CNT_W'(1);
        c_reg <= fa_c;
        Sum   <= {fa_s, Sum[WIDTH-1:1]};
        if (last) Carry <= fa_c;
      end
    end
  end
endmodule
